// File: rtl/regfile_pkg.sv
// Shared register-file constants: datapath widths and the zero register.
package regfile_pkg;
   localparam int         DATA_W = 64;
   localparam int         ADDR_W = 5;
   localparam logic [4:0] XZR    = 5'd31;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the pointer
// remembers which requester won the most recent acceptance.
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic valid0,
   input  logic valid1,
   output logic ready0,
   output logic ready1
);

   // last = 1 means requester 1 was granted most recently
   logic last;

   // grant: single requester wins outright, contention goes to the other side
   always_comb begin
      ready0 = 1'b0;
      ready1 = 1'b0;
      if (reset) begin
         if (valid0 && valid1) begin
            ready0 = last;
            ready1 = !last;
         end else begin
            ready0 = valid0;
            ready1 = valid1;
         end
      end
   end

   // pointer moves only on acceptance; reset makes requester 0 win first
   always_ff @(posedge clk) begin
      if (!reset)
         last <= 1'b1;
      else if (ready0 || ready1)
         last <= ready1;
   end

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: merges execute and load writebacks into
// one registered write port, suppresses writes to XZR, flags read hazards
// against the write in flight and counts committed writes.
module regfile_wr_arb #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [DATA_W-1:0] wd0,
   input  logic              valid1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [DATA_W-1:0] wd1,
   output logic              ready0,
   output logic              ready1,
   output logic              we3,
   output logic [ADDR_W-1:0] wa3,
   output logic [DATA_W-1:0] wd3,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic              hit1,
   output logic              hit2,
   output logic [15:0]       commits
);
   import regfile_pkg::*;

   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(XZR);

   logic              accept;
   logic [ADDR_W-1:0] sel_wa;
   logic [DATA_W-1:0] sel_wd;

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .valid0 (valid0),
      .valid1 (valid1),
      .ready0 (ready0),
      .ready1 (ready1)
   );

   // ready already implies valid, so any ready is an acceptance
   assign accept = ready0 || ready1;
   assign sel_wa = ready1 ? wa1 : wa0;
   assign sel_wd = ready1 ? wd1 : wd0;

   // write port register: address/data hold when idle, only we3 drops
   always_ff @(posedge clk) begin
      if (!reset) begin
         we3 <= 1'b0;
         wa3 <= '0;
         wd3 <= '0;
      end else if (accept) begin
         we3 <= (sel_wa != ZR);
         wa3 <= sel_wa;
         wd3 <= sel_wd;
      end else begin
         we3 <= 1'b0;
      end
   end

   // commit counter: one per edge where the write port is enabled, wraps
   always_ff @(posedge clk) begin
      if (!reset)
         commits <= 16'h0000;
      else if (we3)
         commits <= commits + 16'd1;
   end

   // XZR reads never hazard since the register file returns zero for it
   assign hit1 = we3 && (wa3 == ra1) && (ra1 != ZR);
   assign hit2 = we3 && (wa3 == ra2) && (ra2 != ZR);

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb with hand-computed expectations.
module tb_regfile_wr_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid0, valid1;
   logic [4:0]  wa0, wa1, ra1, ra2, wa3;
   logic [63:0] wd0, wd1, wd3;
   logic        ready0, ready1, we3, hit1, hit2;
   logic [15:0] commits;

   int total = 0;
   int bad   = 0;

   regfile_wr_arb dut (
      .clk(clk), .reset(reset),
      .valid0(valid0), .wa0(wa0), .wd0(wd0),
      .valid1(valid1), .wa1(wa1), .wd1(wd1),
      .ready0(ready0), .ready1(ready1),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2),
      .commits(commits)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      valid0 = 1'b1; valid1 = 1'b1;
      wa0 = 5'd4; wa1 = 5'd6; wd0 = 64'h44; wd1 = 64'h66;
      ra1 = 5'd0; ra2 = 5'd0;

      // reset with both requesters asserting
      tick(); tick();
      chk("rst_ready0", ready0, 0);
      chk("rst_ready1", ready1, 0);
      chk("rst_we3", we3, 0);
      chk("rst_wa3", wa3, 0);
      chk("rst_wd3", wd3, 0);
      chk("rst_commits", commits, 0);

      reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
      tick();
      chk("idle_we3", we3, 0);

      // single request from requester 0
      valid0 = 1'b1; wa0 = 5'd5; wd0 = 64'hCAFE_CAFE_CAFE;
      #1;
      chk("single_ready0", ready0, 1);
      chk("single_ready1", ready1, 0);
      tick();
      valid0 = 1'b0;
      chk("single_we3", we3, 1);
      chk("single_wa3", wa3, 5);
      chk("single_wd3", wd3, 64'hCAFE_CAFE_CAFE);
      tick();
      chk("single_commits", commits, 1);
      chk("single_we3_drop", we3, 0);
      chk("single_wa3_hold", wa3, 5);
      chk("single_wd3_hold", wd3, 64'hCAFE_CAFE_CAFE);

      // hazard against the write in flight
      valid0 = 1'b1; wa0 = 5'd7; wd0 = 64'h77;
      tick();
      valid0 = 1'b0; ra1 = 5'd7; ra2 = 5'd31;
      #1;
      chk("haz_hit1", hit1, 1);
      chk("haz_hit2", hit2, 0);
      ra2 = 5'd7;
      #1;
      chk("haz_hit2_match", hit2, 1);
      tick();
      chk("haz_hit1_idle", hit1, 0);
      chk("haz_commits", commits, 2);

      // XZR write is consumed without committing
      valid1 = 1'b1; wa1 = 5'd31; wd1 = 64'hFFFF;
      #1;
      chk("xzr_ready1", ready1, 1);
      chk("xzr_ready0", ready0, 0);
      tick();
      valid1 = 1'b0; ra1 = 5'd31;
      chk("xzr_we3", we3, 0);
      chk("xzr_hit1", hit1, 0);
      tick();
      chk("xzr_commits", commits, 2);

      // reset while a write is in flight; pointer now favours requester 1
      valid0 = 1'b1; wa0 = 5'd3; wd0 = 64'h33;
      #1;
      chk("mid_ready0", ready0, 1);
      tick();
      chk("mid_we3_pre", we3, 1);
      reset = 1'b0; valid1 = 1'b1;
      #1;
      chk("mid_rst_ready0", ready0, 0);
      chk("mid_rst_ready1", ready1, 0);
      tick();
      chk("mid_we3", we3, 0);
      chk("mid_wa3", wa3, 0);
      chk("mid_commits", commits, 0);
      chk("mid_rst_ready0_b", ready0, 0);
      reset = 1'b1;

      // contention after reset: 0,1,0,1
      wa0 = 5'd1; wd0 = 64'h11; wa1 = 5'd2; wd1 = 64'h22;
      #1;
      chk("cont_g0_ready0", ready0, 1);
      chk("cont_g0_ready1", ready1, 0);
      tick();
      chk("cont_g1_ready1", ready1, 1);
      chk("cont_g1_ready0", ready0, 0);
      chk("cont_wa3_0", wa3, 1);
      chk("cont_we3_0", we3, 1);
      tick();
      chk("cont_g2_ready0", ready0, 1);
      chk("cont_wa3_1", wa3, 2);
      chk("cont_wd3_1", wd3, 64'h22);
      chk("cont_we3_1", we3, 1);
      tick();
      chk("cont_g3_ready1", ready1, 1);
      chk("cont_wa3_2", wa3, 1);
      chk("cont_we3_2", we3, 1);
      tick();
      valid0 = 1'b0; valid1 = 1'b0;
      chk("cont_wa3_3", wa3, 2);
      chk("cont_we3_3", we3, 1);
      chk("cont_commits_3", commits, 3);
      tick();
      chk("cont_commits", commits, 4);
      chk("cont_we3_end", we3, 0);

      // counter wrap: back-to-back writes up to 16'hFFFF then one more
      valid0 = 1'b1; wa0 = 5'd9; wd0 = 64'h99;
      repeat (65532) tick();
      chk("wrap_ffff", commits, 16'hFFFF);
      chk("wrap_we3", we3, 1);
      valid0 = 1'b0;
      tick();
      chk("wrap_zero", commits, 16'h0000);
      chk("wrap_we3_end", we3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
